// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo: FWFT AXI4-Stream buffer with sideband storage, null-beat drop, ready-timeout monitor and status
module axis_stream_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ID_WIDTH      = 8,
  parameter int DEST_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter int DROP_NULL     = 0,
  parameter int READY_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [ID_WIDTH-1:0]       s_tid,
  input  logic [DEST_WIDTH-1:0]     s_tdest,
  input  logic [DATA_WIDTH/8-1:0]   s_tstrb,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic                      s_tlast,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [ID_WIDTH-1:0]       m_tid,
  output logic [DEST_WIDTH-1:0]     m_tdest,
  output logic [DATA_WIDTH/8-1:0]   m_tstrb,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic                      m_tlast,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic [15:0]               pkt_count,
  output logic                      timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + 2 * KW + 1;
  localparam int CW = $clog2(READY_TIMEOUT + 1);
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_fill;
  logic          r_live;
  logic [CW-1:0] r_wait;
  logic [15:0]   r_pkt;
  logic          r_err;
  logic          w_push;
  logic          w_pop;
  logic          w_null;
  logic          w_wr;
  logic          w_stall;
  logic [EW-1:0] w_head;
  // r_live holds tready low until the first edge after reset release
  assign s_axis_tready = r_live && (r_fill != (AW+1)'(DEPTH));
  assign m_axis_tvalid = (r_fill != '0);
  assign w_push  = s_axis_tvalid & s_axis_tready;
  assign w_pop   = m_axis_tvalid & m_axis_tready;
  assign w_null  = (DROP_NULL != 0) && (s_tkeep == '0) && !s_tlast;
  assign w_wr    = w_push & ~w_null;
  assign w_stall = m_axis_tvalid & ~m_axis_tready;
  assign w_head  = r_mem[r_rptr];
  assign {m_axis_tdata, m_tid, m_tdest, m_tstrb, m_tkeep, m_tlast} = w_head;
  assign fill_level  = r_fill;
  assign pkt_count   = r_pkt;
  assign timeout_err = r_err;
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {s_axis_tdata, s_tid, s_tdest, s_tstrb, s_tkeep, s_tlast};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
      r_live <= 1'b0;
      r_wait <= '0;
      r_pkt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_fill <= r_fill + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      if (w_pop && m_tlast) r_pkt <= r_pkt + 16'd1;
      // wait counter saturates at the limit; err latches on the cycle it gets there
      r_wait <= w_stall ? ((r_wait == CW'(READY_TIMEOUT)) ? r_wait : r_wait + CW'(1)) : '0;
      if (w_stall && (r_wait >= CW'(READY_TIMEOUT - 1))) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb_axis_stream_fifo: directed stimulus against a queue-based reference model checked every cycle
module tb_axis_stream_fifo;
  localparam int DEPTH = 4;
  localparam int RT    = 16;
  typedef struct packed {
    logic [7:0] d;
    logic [7:0] id;
    logic [3:0] dst;
    logic       s;
    logic       k;
    logic       l;
  } beat_t;
  logic       clk = 0;
  logic       rst = 0;
  logic [7:0] s_data = 0;
  logic       s_valid = 0;
  logic       s_ready;
  logic [7:0] s_tid = 0;
  logic [3:0] s_tdest = 0;
  logic       s_strb = 0;
  logic       s_keep = 0;
  logic       s_last = 0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 0;
  logic [7:0] m_tid;
  logic [3:0] m_tdest;
  logic       m_tstrb;
  logic       m_tkeep;
  logic       m_tlast;
  logic [2:0] fill_level;
  logic [15:0] pkt_count;
  logic       timeout_err;
  int n_cmp = 0;
  int n_bad = 0;
  beat_t q[$];
  logic [7:0] cap[$];
  bit  live = 0;
  bit  err = 0;
  int  run = 0;
  logic [15:0] pk = 0;
  int  maxfill = 0;
  axis_stream_fifo #(.DATA_WIDTH(8), .ID_WIDTH(8), .DEST_WIDTH(4), .DEPTH(DEPTH),
                     .DROP_NULL(1), .READY_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_tid(s_tid), .s_tdest(s_tdest), .s_tstrb(s_strb), .s_tkeep(s_keep), .s_tlast(s_last),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_tid(m_tid), .m_tdest(m_tdest), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .fill_level(fill_level), .pkt_count(pkt_count), .timeout_err(timeout_err)
  );
  initial forever #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    bit pop, push;
    if (rst) begin
      q.delete();
      live = 0; err = 0; run = 0; pk = 0;
    end else begin
      pop  = (q.size() != 0) && m_ready;
      push = s_valid && live && (q.size() != DEPTH);
      run  = (q.size() != 0 && !m_ready) ? run + 1 : 0;
      if (run >= RT) err = 1;
      if (pop) begin
        if (q[0].l) pk++;
        void'(q.pop_front());
      end
      if (push && !(s_keep == 0 && !s_last))
        q.push_back({s_data, s_tid, s_tdest, s_strb, s_keep, s_last});
      live = 1;
    end
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    step();
  end
  initial forever begin
    @(negedge clk);
    chk("tvalid", m_valid, q.size() != 0);
    chk("fill", fill_level, q.size());
    chk("tready", s_ready, live && q.size() != DEPTH);
    chk("pkt", pkt_count, pk);
    chk("err", timeout_err, err);
    if (q.size() != 0) chk("head", {m_data, m_tid, m_tdest, m_tstrb, m_tkeep, m_tlast}, q[0]);
    if (m_valid && m_ready) cap.push_back(m_data);
    if (int'(fill_level) > maxfill) maxfill = fill_level;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [7:0] d, input logic k, input logic l);
    s_valid = 1; s_data = d; s_keep = k; s_strb = k; s_last = l;
  endtask
  task automatic send(input logic [7:0] d, input logic k, input logic l);
    drive(d, k, l);
    for (int i = 0; i < 50 && !s_ready; i++) tick();
    chk("send_wait", s_ready, 1);
    tick();
    s_valid = 0;
  endtask
  initial begin
    int w;
    #1 rst = 1;
    repeat (3) tick();
    chk("rst_tready", s_ready, 0);
    chk("rst_tvalid", m_valid, 0);
    chk("rst_fill", fill_level, 0);
    rst = 0;
    tick();
    chk("ready_after_rst", s_ready, 1);
    m_ready = 1; cap.delete(); maxfill = 0;
    drive(8'h11, 1, 0); tick();
    drive(8'h22, 1, 0); tick();
    drive(8'h33, 1, 0); tick();
    s_valid = 0;
    repeat (3) tick();
    chk("t1_n", cap.size(), 3);
    for (int i = 0; i < 3 && i < cap.size(); i++) chk("t1_data", cap[i], 8'h11 * (i + 1));
    chk("t1_maxfill", maxfill, 1);
    cap.delete(); m_ready = 0;
    for (int i = 0; i < 4; i++) send(8'h11 * (i + 1), 1, 0);
    drive(8'h55, 1, 0);
    repeat (3) tick();
    chk("t2_full_fill", fill_level, 4);
    chk("t2_full_tready", s_ready, 0);
    m_ready = 1; w = 0;
    while (!s_ready && w < 50) begin tick(); w++; end
    chk("t2_accept_after_pop", w, 1);
    tick();
    s_valid = 0;
    repeat (6) tick();
    chk("t2_n", cap.size(), 5);
    for (int i = 0; i < 5 && i < cap.size(); i++) chk("t2_data", cap[i], 8'h11 * (i + 1));
    cap.delete(); m_ready = 0;
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i), 1, 0);
    m_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(8'h33 + 8'(i), 1, 0);
      tick();
      chk("t3_fill", fill_level, 3);
    end
    s_valid = 0;
    repeat (6) tick();
    chk("t3_n", cap.size(), 13);
    for (int i = 0; i < 13 && i < cap.size(); i++) chk("t3_data", cap[i], 8'h30 + 8'(i));
    cap.delete(); m_ready = 1;
    drive(8'hA1, 1, 0); tick();
    drive(8'hA2, 0, 0); tick();
    drive(8'hA3, 0, 1); tick();
    s_valid = 0;
    repeat (4) tick();
    chk("t4_n", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("t4_first", cap[0], 8'hA1);
      chk("t4_second", cap[1], 8'hA3);
    end
    chk("t4_pkt", pkt_count, 1);
    m_ready = 0;
    s_tid = 8'hA5; s_tdest = 4'h9;
    drive(8'h5A, 1, 1); tick();
    s_valid = 0; s_tid = 0; s_tdest = 0;
    tick();
    chk("t5_data", m_data, 8'h5A);
    chk("t5_tid", m_tid, 8'hA5);
    chk("t5_tdest", m_tdest, 4'h9);
    chk("t5_strb", m_tstrb, 1);
    chk("t5_keep", m_tkeep, 1);
    chk("t5_last", m_tlast, 1);
    m_ready = 1;
    tick();
    chk("t5_pkt", pkt_count, 2);
    m_ready = 0;
    send(8'h66, 1, 0);
    repeat (15) tick();
    chk("t6_err_before", timeout_err, 0);
    tick();
    chk("t6_err_set", timeout_err, 1);
    m_ready = 1;
    repeat (3) tick();
    chk("t6_err_sticky", timeout_err, 1);
    chk("t6_drained", m_valid, 0);
    m_ready = 0;
    send(8'h71, 1, 0);
    send(8'h72, 1, 1);
    drive(8'h73, 1, 0);
    rst = 1;
    #1;
    chk("t6_rst_fill", fill_level, 0);
    chk("t6_rst_tvalid", m_valid, 0);
    chk("t6_rst_tready", s_ready, 0);
    chk("t6_rst_err", timeout_err, 0);
    chk("t6_rst_pkt", pkt_count, 0);
    s_valid = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    chk("t6_ready_again", s_ready, 1);
    cap.delete(); m_ready = 1;
    send(8'h81, 1, 0);
    repeat (3) tick();
    chk("t6_post_n", cap.size(), 1);
    if (cap.size() == 1) chk("t6_post_data", cap[0], 8'h81);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
